// File: rtl/finalizer_rom_loader.sv
// Finalizer ROM loader: splits the index-0 ioctl image into per-region write strobes,
// captures bootleg header and DIP bytes, and gates the core until the image has settled.
module finalizer_rom_loader #(
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter logic [24:0] ROM_END      = 25'h25400
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic [16:0] rom_wr_addr,
  output logic [7:0]  rom_wr_data,
  output logic [4:0]  rom_we,
  output logic        rom_ready,
  output logic        load_err,
  output logic [24:0] byte_count,
  output logic [1:0]  is_bootleg,
  output logic [23:0] dipsw
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam logic [7:0] FlushLast = 8'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [4:0]  rom_we_q, rom_we_d;
  logic [16:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [24:0] byte_count_q, byte_count_d;
  logic        load_err_q, load_err_d;
  logic [1:0]  bootleg_q, bootleg_d;
  logic [7:0]  dip_q [3];
  logic [7:0]  dip_d [3];

  logic        start_load, accept, in_range;
  logic [4:0]  region_we;
  logic [24:0] region_base;

  assign start_load = ioctl_download && (ioctl_index == 8'd0);
  // Bytes are taken for the whole LOAD state, so one arriving with the falling edge of
  // ioctl_download is still written.
  assign accept     = (state_q == StLoad) && ioctl_wr && (ioctl_index == 8'd0);
  assign in_range   = ioctl_addr < ROM_END;

  always_comb begin
    region_we   = 5'b00000;
    region_base = 25'h0;
    if (ioctl_addr < 25'h0C000) begin
      region_we   = 5'b00001;
      region_base = 25'h00000;
    end else if (ioctl_addr < 25'h0D000) begin
      region_we   = 5'b00010;
      region_base = 25'h0C000;
    end else if (ioctl_addr < 25'h1D000) begin
      region_we   = 5'b00100;
      region_base = 25'h0D000;
    end else if (ioctl_addr < 25'h25000) begin
      region_we   = 5'b01000;
      region_base = 25'h1D000;
    end else if (ioctl_addr < 25'h25400) begin
      region_we   = 5'b10000;
      region_base = 25'h25000;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_load) state_d = StLoad;
      end
      StLoad: begin
        if (!ioctl_download) begin
          state_d     = StFlush;
          flush_cnt_d = 8'd0;
        end
      end
      StFlush: begin
        if (start_load) begin
          state_d     = StLoad;
          flush_cnt_d = 8'd0;
        end else if (flush_cnt_q == FlushLast) begin
          state_d = StDone;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rom_we_d     = 5'b00000;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    byte_count_d = byte_count_q;
    load_err_d   = load_err_q;
    bootleg_d    = bootleg_q;
    dip_d        = dip_q;

    if ((state_d == StLoad) && (state_q != StLoad)) begin
      byte_count_d = 25'd0;
      load_err_d   = 1'b0;
    end

    if (accept) begin
      if (in_range && (region_we != 5'b00000)) begin
        rom_we_d     = region_we;
        rom_addr_d   = 17'(ioctl_addr - region_base);
        rom_data_d   = ioctl_data;
        byte_count_d = byte_count_q + 25'd1;
      end else begin
        load_err_d = 1'b1;
      end
    end

    if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
      bootleg_d = ioctl_data[1:0];
    end
    if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'd3)) begin
      dip_d[ioctl_addr[1:0]] = ioctl_data;
    end
  end

  always_ff @(posedge clk_49m) begin
    if (!reset) begin
      state_q      <= StIdle;
      flush_cnt_q  <= 8'd0;
      rom_we_q     <= 5'b00000;
      rom_addr_q   <= 17'd0;
      rom_data_q   <= 8'd0;
      byte_count_q <= 25'd0;
      load_err_q   <= 1'b0;
      bootleg_q    <= 2'b00;
      dip_q[0]     <= 8'hFF;
      dip_q[1]     <= 8'hFF;
      dip_q[2]     <= 8'hFF;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      byte_count_q <= byte_count_d;
      load_err_q   <= load_err_d;
      bootleg_q    <= bootleg_d;
      dip_q        <= dip_d;
    end
  end

  assign rom_we      = rom_we_q;
  assign rom_wr_addr = rom_addr_q;
  assign rom_wr_data = rom_data_q;
  assign rom_ready   = (state_q == StDone);
  assign load_err    = load_err_q;
  assign byte_count  = byte_count_q;
  assign is_bootleg  = bootleg_q;
  assign dipsw       = {~dip_q[2], ~dip_q[1], ~dip_q[0]};

endmodule

// File: tb/tb_finalizer_rom_loader.sv
// Scoreboard bench for finalizer_rom_loader: stimulus pushes expected strobes, a negedge
// monitor pops and checks them, including the one-cycle latency.
module tb_finalizer_rom_loader;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic [16:0] rom_wr_addr;
  logic [7:0]  rom_wr_data;
  logic [4:0]  rom_we;
  logic        rom_ready;
  logic        load_err;
  logic [24:0] byte_count;
  logic [1:0]  is_bootleg;
  logic [23:0] dipsw;

  finalizer_rom_loader dut (
    .clk_49m       (clk_49m),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_data    (ioctl_data),
    .rom_wr_addr   (rom_wr_addr),
    .rom_wr_data   (rom_wr_data),
    .rom_we        (rom_we),
    .rom_ready     (rom_ready),
    .load_err      (load_err),
    .byte_count    (byte_count),
    .is_bootleg    (is_bootleg),
    .dipsw         (dipsw)
  );

  always #5 clk_49m = ~clk_49m;

  typedef struct packed {
    logic [4:0]  we;
    logic [16:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned region_cnt[5];
  logic [31:0] cyc = 0;

  always @(posedge clk_49m) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest expected entry and arrive on its cycle.
  always @(negedge clk_49m) begin
    if (rom_we !== 5'b00000) begin
      for (int i = 0; i < 5; i++) if (rom_we[i] === 1'b1) region_cnt[i]++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got we=%b addr=%0h", rom_we, rom_wr_addr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_we", {27'd0, rom_we}, {27'd0, e.we});
        chk("strobe_addr", {15'd0, rom_wr_addr}, {15'd0, e.addr});
        chk("strobe_data", {24'd0, rom_wr_data}, {24'd0, e.data});
        chk("strobe_latency", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk_49m);
    #1;
  endtask

  // Drive one byte for the next edge; optionally record the strobe it must produce.
  task automatic put(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                     input logic push, input logic [4:0] we, input logic [16:0] la);
    exp_t e;
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_data  = d;
    if (push) begin
      e.we   = we;
      e.addr = la;
      e.data = d;
      e.cyc  = cyc + 1;
      sb_q.push_back(e);
    end
  endtask

  function automatic logic [21:0] region_of(input logic [24:0] a);
    if (a < 25'h0C000) return {5'b00001, 17'(a)};
    if (a < 25'h0D000) return {5'b00010, 17'(a - 25'h0C000)};
    if (a < 25'h1D000) return {5'b00100, 17'(a - 25'h0D000)};
    if (a < 25'h25000) return {5'b01000, 17'(a - 25'h1D000)};
    return {5'b10000, 17'(a - 25'h25000)};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] r;
    for (int i = 0; i < 5; i++) region_cnt[i] = 0;
    #1;
    step(); step(); step();
    chk("rst_we", {27'd0, rom_we}, 32'd0);
    chk("rst_addr", {15'd0, rom_wr_addr}, 32'd0);
    chk("rst_data", {24'd0, rom_wr_data}, 32'd0);
    chk("rst_ready", {31'd0, rom_ready}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_count", {7'd0, byte_count}, 32'd0);
    chk("rst_bootleg", {30'd0, is_bootleg}, 32'd0);
    chk("rst_dipsw", {8'd0, dipsw}, 32'd0);
    reset = 1'b1;
    step();

    // Whole-image sweep at a 16-byte stride; the last byte lands with download falling.
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    step();
    for (int a = 0; a < 32'h25400; a += 16) begin
      r = region_of(25'(a));
      ioctl_download = (a != 32'h253F0);
      put(8'd0, 25'(a), 8'(a), 1'b1, r[21:17], r[16:0]);
      step();
    end
    ioctl_wr = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("ready_at_15", {31'd0, rom_ready}, 32'd0);
    step();
    chk("ready_at_16", {31'd0, rom_ready}, 32'd1);
    chk("sweep_count", {7'd0, byte_count}, 32'h2540);
    chk("sweep_err", {31'd0, load_err}, 32'd0);
    chk("cnt_main", region_cnt[0], 32'hC00);
    chk("cnt_sound", region_cnt[1], 32'h100);
    chk("cnt_sprite", region_cnt[2], 32'h1000);
    chk("cnt_tile", region_cnt[3], 32'h800);
    chk("cnt_prom", region_cnt[4], 32'h40);

    // New download: ready drops, single sprite byte, then hold check.
    ioctl_download = 1'b1;
    step();
    chk("reload_ready", {31'd0, rom_ready}, 32'd0);
    chk("reload_count", {7'd0, byte_count}, 32'd0);
    put(8'd0, 25'h0D005, 8'hA5, 1'b1, 5'b00100, 17'h00005);
    step();
    ioctl_wr = 1'b0;
    chk("single_we", {27'd0, rom_we}, 32'h04);
    chk("single_addr", {15'd0, rom_wr_addr}, 32'h5);
    chk("single_data", {24'd0, rom_wr_data}, 32'hA5);
    step();
    chk("single_we_off", {27'd0, rom_we}, 32'd0);
    chk("hold_addr", {15'd0, rom_wr_addr}, 32'h5);

    // Back-to-back across the main/sound boundary.
    put(8'd0, 25'h0BFFF, 8'h11, 1'b1, 5'b00001, 17'h0BFFF);
    step();
    put(8'd0, 25'h0C000, 8'h22, 1'b1, 5'b00010, 17'h00000);
    step();
    put(8'd0, 25'h0C001, 8'h33, 1'b1, 5'b00010, 17'h00001);
    step();
    ioctl_wr = 1'b0;
    step();
    chk("b2b_count", {7'd0, byte_count}, 32'd4);

    // Out-of-range byte.
    put(8'd0, 25'h25400, 8'h99, 1'b0, 5'b0, 17'd0);
    step();
    ioctl_wr = 1'b0;
    chk("oor_we", {27'd0, rom_we}, 32'd0);
    chk("oor_err", {31'd0, load_err}, 32'd1);
    chk("oor_count", {7'd0, byte_count}, 32'd4);
    ioctl_download = 1'b0;
    step();
    ioctl_download = 1'b1;
    step();
    chk("err_cleared", {31'd0, load_err}, 32'd0);
    ioctl_download = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("ready_again", {31'd0, rom_ready}, 32'd1);

    // DIP and header downloads while DONE.
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(8'd254, 25'(i), 8'h12 + 8'(i) * 8'h22, 1'b0, 5'b0, 17'd0);
      step();
    end
    put(8'd1, 25'd0, 8'h03, 1'b0, 5'b0, 17'd0);
    step();
    put(8'd1, 25'd1, 8'h00, 1'b0, 5'b0, 17'd0);
    step();
    ioctl_wr = 1'b0;
    chk("dipsw", {8'd0, dipsw}, 32'hA9CBED);
    chk("bootleg", {30'd0, is_bootleg}, 32'd3);
    chk("ready_kept", {31'd0, rom_ready}, 32'd1);
    ioctl_download = 1'b0;
    step();

    // Reset asserted with a pending write mid-load.
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    step();
    put(8'd0, 25'h00100, 8'h77, 1'b0, 5'b0, 17'd0);
    reset = 1'b0;
    step();
    ioctl_wr = 1'b0;
    chk("mid_rst_we", {27'd0, rom_we}, 32'd0);
    chk("mid_rst_addr", {15'd0, rom_wr_addr}, 32'd0);
    chk("mid_rst_count", {7'd0, byte_count}, 32'd0);
    chk("mid_rst_dipsw", {8'd0, dipsw}, 32'd0);
    chk("mid_rst_bootleg", {30'd0, is_bootleg}, 32'd0);
    reset = 1'b1;
    step();
    put(8'd0, 25'h25000, 8'h3C, 1'b1, 5'b10000, 17'h00000);
    step();
    ioctl_wr = 1'b0;
    step();
    chk("restart_count", {7'd0, byte_count}, 32'd1);
    ioctl_download = 1'b0;
    step(); step();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
